// File: rtl/tt_vector_harness_if.sv
// Bundles the harness control, load, status and DUT-facing signals.
// Pure wiring: no storage, no latency.
// Load channel is valid/ready; the harness drives ready, the driver holds valid.
interface tt_vector_harness_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = 8
);
    localparam int AW = $clog2(DEPTH);

    // control
    logic             ena;
    logic             clear;
    logic             start;
    logic             loop;
    logic             abort;

    // vector load channel
    logic             ld_valid;
    logic             ld_ready;
    logic [WIDTH-1:0] ld_stim;
    logic [WIDTH-1:0] ld_exp;
    logic [WIDTH-1:0] ld_mask;

    // user-core side
    logic [WIDTH-1:0] stim_out;
    logic [WIDTH-1:0] dut_in;

    // status
    logic             busy;
    logic             done;
    logic             fail;
    logic [CNT_W-1:0] err_cnt;
    logic [AW-1:0]    first_err_idx;
    logic [AW:0]      count;

    // driver side: pins / bench
    modport master (
        output ena, clear, start, loop, abort,
        output ld_valid, ld_stim, ld_exp, ld_mask,
        output dut_in,
        input  ld_ready, stim_out,
        input  busy, done, fail, err_cnt, first_err_idx, count
    );

    // harness side
    modport slave (
        input  ena, clear, start, loop, abort,
        input  ld_valid, ld_stim, ld_exp, ld_mask,
        input  dut_in,
        output ld_ready, stim_out,
        output busy, done, fail, err_cnt, first_err_idx, count
    );
endinterface

// File: rtl/tt_vector_harness.sv
// Stores stimulus/expected/mask vectors, replays them into a user core and scores its outputs.
// stim[i] appears one edge after it is issued; its response is checked LAT+1 enabled edges later.
// ld_ready low while replaying or full; ena=0 freezes every register and drops ld_ready.
module tt_vector_harness #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int LAT   = 0,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    tt_vector_harness_if.slave hif
);
    localparam int              AW         = $clog2(DEPTH);
    localparam int              NST        = LAT + 1;
    localparam logic [AW:0]     FULL       = DEPTH[AW:0];
    localparam logic [2:0]      DRAIN_LAST = (LAT > 0) ? 3'(LAT - 1) : 3'd0;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [AW-1:0]     rd;          // index of the vector currently on stim_out
    logic              loop_q;
    logic [2:0]        drain_cnt;

    // vector memory; contents are don't-care after reset since count restarts at 0
    logic [WIDTH-1:0]  mem_stim [DEPTH];
    logic [WIDTH-1:0]  mem_exp  [DEPTH];
    logic [WIDTH-1:0]  mem_mask [DEPTH];

    // compare pipeline: stage 0 is loaded alongside stim_out, stage LAT is scored
    logic [NST-1:0]    pv;
    logic [WIDTH-1:0]  pe [NST];
    logic [WIDTH-1:0]  pm [NST];
    logic [AW-1:0]     pi [NST];

    logic              idle_like;
    logic              active;
    logic              start_fire;
    logic              abort_fire;
    logic              load_fire;
    logic [AW-1:0]     last_idx;
    logic              at_last;
    logic              run_adv;
    logic              issue;
    logic [AW-1:0]     issue_idx;
    logic              mismatch;

    assign idle_like  = (state == IDLE) || (state == DONE);
    assign active     = (state == RUN)  || (state == DRAIN);

    assign hif.ld_ready = idle_like && (hif.count < FULL) && hif.ena;
    assign hif.busy     = active;
    assign hif.done     = (state == DONE);

    // priority clear > abort > start > load; any higher-priority request drops the load
    assign start_fire = hif.ena && !hif.clear && !hif.abort && hif.start &&
                        idle_like && (hif.count != '0);
    assign abort_fire = hif.ena && !hif.clear && hif.abort && active;
    assign load_fire  = hif.ena && hif.ld_valid && hif.ld_ready &&
                        !hif.clear && !hif.abort && !hif.start;

    // count==DEPTH wraps to 0 in AW bits, so the subtraction still yields DEPTH-1
    assign last_idx  = hif.count[AW-1:0] - AW'(1);
    assign at_last   = (rd == last_idx);
    assign run_adv   = (state == RUN) && !(at_last && !loop_q);

    // a new vector goes out on the start edge and on every RUN edge that is not the final one
    assign issue     = start_fire ||
                       (hif.ena && !hif.clear && !abort_fire && run_adv);
    assign issue_idx = ((state == RUN) && !at_last) ? rd + AW'(1) : '0;

    assign mismatch  = pv[LAT] && (|((hif.dut_in ^ pe[LAT]) & pm[LAT]));

    // vector memory write port
    always_ff @(posedge clk) begin
        if (load_fire) begin
            mem_stim[hif.count[AW-1:0]] <= hif.ld_stim;
            mem_exp[hif.count[AW-1:0]]  <= hif.ld_exp;
            mem_mask[hif.count[AW-1:0]] <= hif.ld_mask;
        end
    end

    // valid bits of the compare pipeline; flushed on clear and abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
        end else if (hif.ena) begin
            if (hif.clear || abort_fire) begin
                pv <= '0;
            end else begin
                pv[0] <= issue;
                for (int k = 1; k < NST; k++) begin
                    pv[k] <= pv[k-1];
                end
            end
        end
    end

    // expected/mask/index payload travelling with the valid bits
    always_ff @(posedge clk) begin
        if (hif.ena) begin
            pe[0] <= mem_exp[issue_idx];
            pm[0] <= mem_mask[issue_idx];
            pi[0] <= issue_idx;
            for (int k = 1; k < NST; k++) begin
                pe[k] <= pe[k-1];
                pm[k] <= pm[k-1];
                pi[k] <= pi[k-1];
            end
        end
    end

    // control FSM with registered stimulus, vector count and error status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            rd                <= '0;
            loop_q            <= 1'b0;
            drain_cnt         <= '0;
            hif.stim_out      <= '0;
            hif.count         <= '0;
            hif.err_cnt       <= '0;
            hif.fail          <= 1'b0;
            hif.first_err_idx <= '0;
        end else if (hif.ena) begin
            if (hif.clear) begin
                state             <= IDLE;
                hif.stim_out      <= '0;
                hif.count         <= '0;
                hif.err_cnt       <= '0;
                hif.fail          <= 1'b0;
                hif.first_err_idx <= '0;
            end else begin
                // scoring: a fresh start wipes status, otherwise record the mismatch
                if (start_fire) begin
                    hif.err_cnt       <= '0;
                    hif.fail          <= 1'b0;
                    hif.first_err_idx <= '0;
                end else if (mismatch) begin
                    hif.fail <= 1'b1;
                    if (hif.err_cnt != CNT_MAX) begin
                        hif.err_cnt <= hif.err_cnt + CNT_W'(1);
                    end
                    if (!hif.fail) begin
                        hif.first_err_idx <= pi[LAT];
                    end
                end

                if (load_fire) begin
                    hif.count <= hif.count + (AW+1)'(1);
                end

                case (state)
                    IDLE, DONE: begin
                        if (start_fire) begin
                            state        <= RUN;
                            rd           <= '0;
                            loop_q       <= hif.loop;
                            hif.stim_out <= mem_stim[issue_idx];
                        end
                    end
                    RUN: begin
                        if (hif.abort) begin
                            state        <= IDLE;
                            hif.stim_out <= '0;
                        end else if (at_last && !loop_q) begin
                            drain_cnt <= '0;
                            if (LAT == 0) begin
                                state        <= DONE;
                                hif.stim_out <= '0;
                            end else begin
                                state <= DRAIN;
                            end
                        end else begin
                            rd           <= issue_idx;
                            hif.stim_out <= mem_stim[issue_idx];
                        end
                    end
                    DRAIN: begin
                        if (hif.abort) begin
                            state        <= IDLE;
                            hif.stim_out <= '0;
                        end else if (drain_cnt == DRAIN_LAST) begin
                            state        <= DONE;
                            hif.stim_out <= '0;
                        end else begin
                            drain_cnt <= drain_cnt + 3'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule
